// File: rtl/bsg_mem_1r1w_sync_mask_init_pkg.sv
// Shared types and constants for the self-initialising 1R1W masked RAM.
package bsg_mem_1r1w_sync_mask_init_pkg;

    typedef enum logic [1:0] {eINIT, eREADY_PEND, eREADY} state_e;

    localparam int e_rw_read_first  = 0;
    localparam int e_rw_write_first = 1;

    // Address width that never collapses to zero bits for a single-entry array.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_mem_1r1w_sync_mask_synth.sv
// Raw storage: bit-masked write and registered read-first read; output holds when no read.
module bsg_mem_1r1w_sync_mask_synth
    import bsg_mem_1r1w_sync_mask_init_pkg::*;
#(
    parameter  int width_p       = 32,
    parameter  int els_p         = 64,
    localparam int addr_width_lp = safe_clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [width_p-1:0]       w_bmask_i,
    input  logic                     r_v_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem[w_addr_i] <= (mem[w_addr_i] & ~w_bmask_i) | (w_data_i & w_bmask_i);
        end
        if (r_v_i) begin
            r_data_o <= mem[r_addr_i];
        end
    end

endmodule

// File: rtl/bsg_mem_1r1w_sync_mask_init.sv
// 1R1W masked RAM with post-reset init sweep, selectable same-address semantics and held read data.
module bsg_mem_1r1w_sync_mask_init
    import bsg_mem_1r1w_sync_mask_init_pkg::*;
#(
    parameter  int                 width_p             = 32,
    parameter  int                 els_p               = 64,
    parameter  int                 mask_gran_p         = 8,
    parameter  int                 rw_same_addr_mode_p = e_rw_read_first,
    parameter  int                 init_p              = 1,
    parameter  logic [width_p-1:0] init_val_p          = '0,
    localparam int                 addr_width_lp       = safe_clog2(els_p),
    localparam int                 mask_width_lp       = width_p / mask_gran_p
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    output logic                     ready_o,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [mask_width_lp-1:0] w_mask_i,
    input  logic                     r_v_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic                     r_v_o,
    output logic [width_p-1:0]       r_data_o
);

    if (width_p % mask_gran_p != 0) begin : g_bad_gran
        $error("width_p must be a multiple of mask_gran_p");
    end
    if (rw_same_addr_mode_p != e_rw_read_first && rw_same_addr_mode_p != e_rw_write_first) begin : g_bad_mode
        $error("rw_same_addr_mode_p must be 0 or 1");
    end
    if (els_p < 1) begin : g_bad_els
        $error("els_p must be at least 1");
    end

    localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);
    localparam logic [addr_width_lp:0]   els_lp       = (addr_width_lp + 1)'(els_p);
    localparam state_e                   reset_state_lp = (init_p != 0) ? eINIT : eREADY_PEND;
    localparam bit                       fwd_en_lp    = (rw_same_addr_mode_p == e_rw_write_first);

    state_e                   state_r, state_n;
    logic [addr_width_lp-1:0] init_cnt_r;
    logic                     w_acc, r_acc, collide;
    logic [width_p-1:0]       bit_mask;

    logic                     mem_w_v;
    logic [addr_width_lp-1:0] mem_w_addr;
    logic [width_p-1:0]       mem_w_data, mem_w_bmask, mem_r_data;

    logic [width_p-1:0]       fwd_mask_r, fwd_data_r, hold_r;

    assign w_acc   = w_v_i & ready_o;
    assign r_acc   = r_v_i & ready_o;
    assign collide = w_acc & (w_addr_i == r_addr_i);

    always_comb begin
        bit_mask = '0;
        for (int k = 0; k < mask_width_lp; k++) begin
            bit_mask[k*mask_gran_p +: mask_gran_p] = {mask_gran_p{w_mask_i[k]}};
        end
    end

    // The sweep owns the write port while in eINIT; user writes are blocked since ready_o is low.
    always_comb begin
        state_n     = state_r;
        mem_w_v     = w_acc;
        mem_w_addr  = w_addr_i;
        mem_w_data  = w_data_i;
        mem_w_bmask = bit_mask;
        unique case (state_r)
            eINIT: begin
                mem_w_v     = 1'b1;
                mem_w_addr  = init_cnt_r;
                mem_w_data  = init_val_p;
                mem_w_bmask = '1;
                if (init_cnt_r == last_addr_lp) begin
                    state_n = eREADY_PEND;
                end
            end
            eREADY_PEND: state_n = eREADY;
            default:     state_n = state_r;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r    <= reset_state_lp;
            init_cnt_r <= '0;
            ready_o    <= 1'b0;
        end else begin
            state_r <= state_n;
            ready_o <= (state_n == eREADY);
            if (state_r == eINIT) begin
                init_cnt_r <= init_cnt_r + 1'b1;
            end
        end
    end

    bsg_mem_1r1w_sync_mask_synth #(
        .width_p (width_p),
        .els_p   (els_p)
    ) u_synth (
        .clk_i     (clk_i),
        .w_v_i     (mem_w_v),
        .w_addr_i  (mem_w_addr),
        .w_data_i  (mem_w_data),
        .w_bmask_i (mem_w_bmask),
        .r_v_i     (r_acc),
        .r_addr_i  (r_addr_i),
        .r_data_o  (mem_r_data)
    );

    // Forwarding lanes are captured with the read; an empty mask yields plain read-first data.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_v_o      <= 1'b0;
            fwd_mask_r <= '0;
            fwd_data_r <= '0;
            hold_r     <= '0;
        end else begin
            r_v_o <= r_acc;
            if (r_acc) begin
                fwd_mask_r <= (fwd_en_lp && collide) ? bit_mask : '0;
                fwd_data_r <= w_data_i;
            end
            if (r_v_o) begin
                hold_r <= r_data_o;
            end
        end
    end

    assign r_data_o = r_v_o ? ((mem_r_data & ~fwd_mask_r) | (fwd_data_r & fwd_mask_r)) : hold_r;

    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!w_acc || ({1'b0, w_addr_i} < els_lp))
                else $error("write address out of range");
            assert (!r_acc || ({1'b0, r_addr_i} < els_lp))
                else $error("read address out of range");
        end
    end

endmodule

// File: tb/tb_bsg_mem_1r1w_sync_mask_init.sv
// Randomised and directed bench for three RAM configurations sharing one stimulus stream.
module tb_bsg_mem_1r1w_sync_mask_init;

    localparam int W = 32;
    localparam int N = 64;
    localparam int G = 8;
    localparam int M = W / G;
    localparam int A = 6;
    localparam logic [W-1:0] IV = 32'hDEADBEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         w_v, r_v;
    logic [A-1:0] w_addr, r_addr;
    logic [W-1:0] w_data;
    logic [M-1:0] w_mask;

    logic [2:0]        rdy, rvo;
    logic [2:0][W-1:0] rdo;

    // instance 0: read-first with init, 1: write-first with init, 2: no init
    bsg_mem_1r1w_sync_mask_init #(.width_p(W), .els_p(N), .mask_gran_p(G), .rw_same_addr_mode_p(0),
        .init_p(1), .init_val_p(IV)) dut_a (
        .clk_i(clk), .reset_i(rst), .ready_o(rdy[0]), .w_v_i(w_v), .w_addr_i(w_addr), .w_data_i(w_data),
        .w_mask_i(w_mask), .r_v_i(r_v), .r_addr_i(r_addr), .r_v_o(rvo[0]), .r_data_o(rdo[0]));
    bsg_mem_1r1w_sync_mask_init #(.width_p(W), .els_p(N), .mask_gran_p(G), .rw_same_addr_mode_p(1),
        .init_p(1), .init_val_p(IV)) dut_b (
        .clk_i(clk), .reset_i(rst), .ready_o(rdy[1]), .w_v_i(w_v), .w_addr_i(w_addr), .w_data_i(w_data),
        .w_mask_i(w_mask), .r_v_i(r_v), .r_addr_i(r_addr), .r_v_o(rvo[1]), .r_data_o(rdo[1]));
    bsg_mem_1r1w_sync_mask_init #(.width_p(W), .els_p(N), .mask_gran_p(G), .rw_same_addr_mode_p(0),
        .init_p(0), .init_val_p(IV)) dut_c (
        .clk_i(clk), .reset_i(rst), .ready_o(rdy[2]), .w_v_i(w_v), .w_addr_i(w_addr), .w_data_i(w_data),
        .w_mask_i(w_mask), .r_v_i(r_v), .r_addr_i(r_addr), .r_v_o(rvo[2]), .r_data_o(rdo[2]));

    // Reference model: contents, known-bit masks, edges since reset release, expected outputs.
    logic [W-1:0] mem_m [3][N];
    logic [W-1:0] kn_m  [3][N];
    int           cnt   [3];
    logic [W-1:0] exp_d [3];
    logic [W-1:0] exp_k [3];
    logic         exp_v [3];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int lat(input int i);
        return (i == 2) ? 1 : N + 1;
    endfunction

    function automatic logic [W-1:0] lanes(input logic [M-1:0] m);
        logic [W-1:0] r = '0;
        for (int k = 0; k < M; k++) if (m[k]) r[k*G +: G] = '1;
        return r;
    endfunction

    task automatic check_out(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_ready%0d", tag, i), W'(rdy[i]), W'(!rst && cnt[i] >= lat(i)));
            chk($sformatf("%s_rv%0d", tag, i), W'(rvo[i]), W'(exp_v[i]));
            chk($sformatf("%s_rdata%0d", tag, i), rdo[i] & exp_k[i], exp_d[i] & exp_k[i]);
        end
    endtask

    task automatic step(input string tag = "cyc");
        logic [W-1:0] bm, old, ok;
        bit rdy_now, aw, ar;
        bm = lanes(w_mask);
        for (int i = 0; i < 3; i++) begin
            rdy_now = !rst && cnt[i] >= lat(i);
            aw = w_v && rdy_now;
            ar = r_v && rdy_now;
            if (ar) begin
                old = mem_m[i][r_addr];
                ok  = kn_m[i][r_addr];
                if (i == 1 && aw && w_addr == r_addr) begin
                    old = (old & ~bm) | (w_data & bm);
                    ok  = ok | bm;
                end
                exp_d[i] = old;
                exp_k[i] = ok;
            end
            exp_v[i] = ar;
            if (aw) begin
                mem_m[i][w_addr] = (mem_m[i][w_addr] & ~bm) | (w_data & bm);
                kn_m[i][w_addr]  = kn_m[i][w_addr] | bm;
            end
            if (!rst) cnt[i]++;
            // once ready, every entry of a sweeping instance holds the init value
            if (i < 2 && !rst && cnt[i] == lat(i)) begin
                for (int e = 0; e < N; e++) begin
                    mem_m[i][e] = IV;
                    kn_m[i][e]  = '1;
                end
            end
        end
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            cnt[i]   = 0;
            exp_v[i] = 1'b0;
            exp_d[i] = '0;
            exp_k[i] = '1;
        end
        check_out("reset");
        repeat (cycles) step("in_reset");
        rst = 1'b0;
    endtask

    task automatic rand_in();
        w_v    = 1'($urandom_range(0, 1));
        w_addr = A'($urandom_range(0, N - 1));
        w_data = $urandom;
        w_mask = M'($urandom);
        r_v    = 1'($urandom_range(0, 1));
        r_addr = ($urandom_range(0, 3) == 0) ? w_addr : A'($urandom_range(0, N - 1));
    endtask

    task automatic idle();
        w_v = 1'b0;
        r_v = 1'b0;
    endtask

    task automatic wr(input logic [A-1:0] a, input logic [W-1:0] d, input logic [M-1:0] m);
        w_v = 1'b1; w_addr = a; w_data = d; w_mask = m; r_v = 1'b0;
        step("write");
        idle();
    endtask

    task automatic rd(input logic [A-1:0] a);
        r_v = 1'b1; r_addr = a; w_v = 1'b0;
        step("read");
        idle();
    endtask

    initial begin
        rst = 1'b1; w_v = 1'b0; r_v = 1'b0; w_addr = '0; r_addr = '0; w_data = '0; w_mask = '0;
        for (int i = 0; i < 3; i++) for (int e = 0; e < N; e++) begin
            mem_m[i][e] = '0;
            kn_m[i][e]  = '0;
        end
        #2;
        do_reset(2);

        // no-init instance: a write offered while not ready must be dropped
        step();
        wr(6'd3, 32'h12345678, 4'hF);
        w_v = 1'b1; w_addr = 6'd3; w_data = 32'hFFFFFFFF; w_mask = 4'hF;
        do_reset(2);
        step("notready_write");
        idle();
        step();
        rd(6'd3);
        chk("noinit_guard", rdo[2], 32'h12345678);

        // sweep completes; requests during it are ignored by the sweeping instances
        repeat (N) begin rand_in(); step("sweep"); end
        idle();
        repeat (2) step("sweep_end");

        rd(6'd0);  chk("init_e0_a", rdo[0], IV);  chk("init_e0_rv", W'(rvo[0]), W'(1));
        rd(6'd31); chk("init_e31_b", rdo[1], IV);
        rd(6'd63); chk("init_e63_a", rdo[0], IV);

        wr(6'd5, 32'h11223344, 4'b1111);
        wr(6'd5, 32'hAABBCCDD, 4'b0101);
        rd(6'd5);
        chk("mask_a", rdo[0], 32'h11BB33DD);
        chk("mask_b", rdo[1], 32'h11BB33DD);

        wr(6'd9, 32'h0, 4'b1111);
        w_v = 1'b1; w_addr = 6'd9; w_data = 32'hFFFFFFFF; w_mask = 4'b0011;
        r_v = 1'b1; r_addr = 6'd9;
        step("collide");
        idle();
        chk("collide_mode0", rdo[0], 32'h0);
        chk("collide_mode1", rdo[1], 32'h0000FFFF);
        rd(6'd9);
        chk("after_collide_a", rdo[0], 32'h0000FFFF);
        chk("after_collide_b", rdo[1], 32'h0000FFFF);

        wr(6'd1, 32'hCAFEF00D, 4'b1111);
        w_v = 1'b1; w_addr = 6'd1; w_data = 32'h12345678; w_mask = 4'b1111;
        step("b2b_write");
        idle();
        rd(6'd1);
        chk("b2b_a", rdo[0], 32'h12345678);
        chk("b2b_b", rdo[1], 32'h12345678);

        rd(6'd5);
        repeat (10) begin
            step("hold");
            chk("hold_data", rdo[0], 32'h11BB33DD);
        end

        repeat (300) begin rand_in(); step("rand"); end
        idle();

        // entries written just before the reset must come back as the init value
        for (int a = 0; a < 4; a++) wr(A'(a), $urandom, 4'hF);
        do_reset(2);
        repeat (20) begin rand_in(); step("sweep1"); end
        do_reset(2);
        repeat (N + 1) begin rand_in(); step("sweep2"); end
        idle();
        step();
        for (int a = 0; a < N; a++) begin
            rd(A'(a));
            chk($sformatf("resweep_a%0d", a), rdo[0], IV);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
